// File: rtl/add_subb_pipe.sv
// Pipelined signed add/subtract s = (+/-a) + (+/-b) with the carry chain split over STAGES
// registers, valid/ready backpressure and a saturating overflow counter. Define ADD_SUBB_PIPE_SAT_EN for saturating s.
module add_subb_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             subb_a,
  input  logic             subb_b,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     s,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  // Two guard bits hold the exact result range -2^W..2^W.
  localparam int E    = W + 2;
  localparam int BASE = E / STAGES;
  localparam int REM  = E % STAGES;

  function automatic int chunkLo(input int k);
    return k * BASE + ((k < REM) ? k : REM);
  endfunction

  logic [E-1:0] opA, opB, opC, csaSum, csaCar;
  logic         adv;

  logic [E-1:0]     sumIn [STAGES];
  logic [E-1:0]     carIn [STAGES];
  logic [E-1:0]     resIn [STAGES];
  logic             cIn   [STAGES];
  logic             vIn   [STAGES];
  logic [TAG_W-1:0] tagIn [STAGES];

  logic [E-1:0] res_d [STAGES];
  logic         c_d   [STAGES];

  logic [E-1:0]     sum_q [STAGES];
  logic [E-1:0]     car_q [STAGES];
  logic [E-1:0]     res_q [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];

  logic [CNT_W-1:0] ovfCnt_q, ovfCnt_d;
  logic [E-1:0]     result;
  logic [2:0]       unusedTop;

  // Negation is ~x + 1; both +1 terms fold into a constant third operand of a carry-save step.
  always_comb begin
    opA    = {{2{a[W-1]}}, a} ^ {E{subb_a}};
    opB    = {{2{b[W-1]}}, b} ^ {E{subb_b}};
    opC    = '0;
    opC[1] = subb_a & subb_b;
    opC[0] = subb_a ^ subb_b;
    csaSum = opA ^ opB ^ opC;
    csaCar = ((opA & opB) | (opA & opC) | (opB & opC)) << 1;
  end

  always_comb begin
    sumIn[0] = csaSum;
    carIn[0] = csaCar;
    resIn[0] = '0;
    cIn[0]   = 1'b0;
    vIn[0]   = in_valid;
    tagIn[0] = tag;
    for (int k = 1; k < STAGES; k++) begin
      sumIn[k] = sum_q[k-1];
      carIn[k] = car_q[k-1];
      resIn[k] = res_q[k-1];
      cIn[k]   = c_q[k-1];
      vIn[k]   = v_q[k-1];
      tagIn[k] = tag_q[k-1];
    end
  end

  // Stage k ripples only its own slice of bits and hands the carry to the next stage.
  always_comb begin
    logic         carry;
    logic [E-1:0] res;
    carry = 1'b0;
    res   = '0;
    for (int k = 0; k < STAGES; k++) begin
      carry = cIn[k];
      res   = resIn[k];
      for (int i = 0; i < E; i++) begin
        if (i >= chunkLo(k) && i < chunkLo(k + 1)) begin
          res[i] = sumIn[k][i] ^ carIn[k][i] ^ carry;
          carry  = (sumIn[k][i] & carIn[k][i]) | (carry & (sumIn[k][i] ^ carIn[k][i]));
        end
      end
      res_d[k] = res;
      c_d[k]   = carry;
    end
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        car_q[k] <= '0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sumIn[k];
        car_q[k] <= carIn[k];
        res_q[k] <= res_d[k];
        c_q[k]   <= c_d[k];
        v_q[k]   <= vIn[k];
        tag_q[k] <= tagIn[k];
      end
    end
  end

  // Overflow whenever the guard bits and the W-bit sign bit disagree.
  assign result    = res_q[STAGES-1];
  assign unusedTop = result[E-1:W-1];
  assign ovf       = !((&unusedTop) || !(|unusedTop));
  assign out_valid = v_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];

`ifdef ADD_SUBB_PIPE_SAT_EN
  assign s = ovf ? (result[E-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                 : result[W-1:0];
`else
  assign s = result[W-1:0];
`endif

  always_comb begin
    ovfCnt_d = ovfCnt_q;
    if (cnt_clr) begin
      ovfCnt_d = '0;
    end else if (out_valid && out_ready && ovf && (ovfCnt_q != {CNT_W{1'b1}})) begin
      ovfCnt_d = ovfCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovfCnt_q <= '0;
    else     ovfCnt_q <= ovfCnt_d;
  end

  assign ovf_cnt = ovfCnt_q;

endmodule

// File: doc/add_subb_pipe.md
Name: add_subb_pipe

Overview:
- Pipelined, parametrised successor of the combinational add/subtract cell used in the BKM FPU datapath.
- Computes s = (±a) + (±b) on signed W-bit operands, with independent negate flags per operand.
- The carry chain is split across STAGES register stages, and a valid/ready handshake with full backpressure is provided.
- Carries a sideband tag and keeps a saturating overflow-event counter for iteration monitoring.

Parameters:
- W, 16, operand/result width in bits (signed two's complement), W >= 2.
- STAGES, 2, pipeline register stages = input-to-output latency in cycles, 1 <= STAGES <= W.
- TAG_W, 4, width of sideband tag passed through with each operation.
- CNT_W, 8, width of saturating overflow-event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- subb_a  in  1  1: negate a before addition.
- subb_b  in  1  1: negate b before addition.
- a  in  W  signed operand A.
- b  in  W  signed operand B.
- tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  W  signed result.
- ovf  out  1  signed overflow of the result.
- tag_out  out  TAG_W  tag of the current result.
- ovf_cnt  out  CNT_W  number of accepted-out results with ovf=1, saturating.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Exact result: R = (subb_a ? -a : a) + (subb_b ? -b : b), computed without loss (range -2^W..2^W).
- s = R mod 2^W.
- ovf = 1 iff R < -2^(W-1) or R > 2^(W-1)-1. This includes the case a = -2^(W-1) with subb_a=1 and b=0.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Pipeline advance: adv = !out_valid | out_ready; in_ready = adv (combinational from out_ready and state).
- Whole pipeline stalls when adv=0. All stage registers, valid bits and tags hold.
- Latency: a result appears on out_valid exactly STAGES cycles after input transfer when no stall occurs.
- Throughput: 1 op/cycle.
- Carry partitioning: each stage resolves roughly ceil(W/STAGES) bits of the carry chain. Partitioning is internal; only latency and results are specified.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0. s, ovf and tag_out are don't-care while out_valid=0 but must remain stable while out_valid=1 & out_ready=0.
- ovf_cnt:
  - Increments by 1 on each output transfer with ovf=1.
  - Holds at 2^CNT_W-1 (no wrap).
  - When cnt_clr and an increment occur in the same cycle, the counter goes to 0; clear wins and the event is dropped.
- Reset:
  - out_valid=0, all stage valid bits=0, ovf_cnt=0, s=0, ovf=0, tag_out=0.
  - in_ready=1 in the first cycle after reset (pipeline empty).
  - Reset mid-operation discards all in-flight ops; no result for them is ever presented.
- Out of reset, in_valid is ignored while rst=1.

Optional Feature:
- Macro: ADD_SUBB_PIPE_SAT_EN.
- Defined: when ovf=1, s saturates to 2^(W-1)-1 if R>0, or -2^(W-1) if R<0. ovf still asserts. Latency is unchanged.
- Undefined: s wraps modulo 2^W as above.

Test Plan:
All scenarios use W=4, STAGES=2, macro undefined unless noted.
- Basic ops:
  - a=3, b=2, subb=00 -> s=5, ovf=0.
  - subb=01 -> s=1.
  - subb=11, a=3, b=4 -> s=-7, ovf=0.
  - Each appears with out_valid exactly 2 cycles after acceptance, tag echoed.
- Overflow/wrap:
  - a=5, b=3, subb=00 -> s=-8, ovf=1.
  - a=-8, b=0, subb=10 -> s=-8, ovf=1.
  - With ADD_SUBB_PIPE_SAT_EN: s=7 for both.
  - a=-8, b=1, subb=01 -> s=-8 with SAT_EN (R=-9).
- Backpressure:
  - Stream 5 ops back-to-back with tags 1..5; hold out_ready=0 for 3 cycles starting when tag 1 is presented.
  - Required: in_ready=0 during the stall, s/tag_out stable, all 5 results delivered in order, none lost or duplicated.
- Full throughput: 16 ops on consecutive cycles with out_ready=1 -> 16 results on 16 consecutive cycles, matching a reference model.
- Counter:
  - With CNT_W=2, deliver 5 overflowing ops -> ovf_cnt = 1, 2, 3, 3, 3.
  - Assert cnt_clr on the same cycle as an ovf transfer -> ovf_cnt=0.
- Reset mid-flight: accept 2 ops, assert rst 1 cycle later -> out_valid stays 0 after reset, ovf_cnt=0, in_ready=1, and the next op returns the correct result with latency 2.
